// File: rtl/sevseg_scan.sv
// sevseg_scan: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler divides the clock into digit slots. Each slot starts with a short blanking
// window that suppresses ghosting. The frame is decoded from a snapshot register, which is
// reloaded once per frame so that a changing input never tears the displayed value.
// Optional feature: define SEVSEG_SCAN_LZB_EN to enable leading-zero blanking.
module sevseg_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        sevseg_scan_clk,
    input  logic        sevseg_scan_rst,
    input  logic [15:0] sevseg_scan_bcd,
    input  logic [3:0]  sevseg_scan_dp_en,
    output logic [3:0]  sevseg_scan_an,
    output logic [6:0]  sevseg_scan_seg,
    output logic        sevseg_scan_dp,
    output logic        sevseg_scan_frame
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);

    logic [PW-1:0] presc_reg;
    logic [1:0]    idx_reg;
    logic [15:0]   snap_bcd_reg;
    logic [3:0]    snap_dp_reg;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic          frame_reg;

    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic          presc_last;
    logic          frame_load;
    logic          in_blank;

    logic [3:0]    digit_code [4];
    logic [3:0]    digit_blank;

    // Standard active-low {g,f,e,d,c,b,a} patterns; non-decimal codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign presc_last = (presc_reg == PRESC_LAST);
    assign frame_load = presc_last && (idx_reg == 2'd3);
    assign in_blank   = (presc_reg < BLANK_LIM);

`ifdef SEVSEG_SCAN_LZB_EN
    // lead_zero[k]: snapshot digits k..3 are all zero (codes 10..15 count as nonzero).
    logic [3:0] lead_zero;
`endif

    // Per-digit code slices and leading-zero blanking flags.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign digit_code[gi] = snap_bcd_reg[4*gi +: 4];
`ifdef SEVSEG_SCAN_LZB_EN
        assign lead_zero[gi] = (snap_bcd_reg[15:4*gi] == '0);
        if (gi == 0) begin : g_units
            // The units digit is always shown so that zero reads as "0".
            assign digit_blank[gi] = 1'b0;
        end else begin : g_upper
            // A requested decimal point keeps an otherwise-leading zero visible.
            assign digit_blank[gi] = lead_zero[gi] & ~snap_dp_reg[gi];
        end
`else
        assign digit_blank[gi] = 1'b0;
`endif
    end

    // Output decode from the current scan state; registered below for one-cycle latency.
    always_comb begin
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (!in_blank && !digit_blank[idx_reg]) begin
            an_next[idx_reg] = 1'b0;
            seg_next         = decode(digit_code[idx_reg]);
            dp_next          = ~snap_dp_reg[idx_reg];
        end
    end

    // Prescaler, digit index and once-per-frame snapshot of the inputs.
    always_ff @(posedge sevseg_scan_clk or posedge sevseg_scan_rst) begin
        if (sevseg_scan_rst) begin
            presc_reg    <= '0;
            idx_reg      <= 2'd0;
            snap_bcd_reg <= 16'h0000;
            snap_dp_reg  <= 4'b0000;
        end else begin
            presc_reg <= presc_last ? '0 : presc_reg + 1'b1;
            if (presc_last) begin
                idx_reg <= idx_reg + 2'd1;
            end
            if (frame_load) begin
                snap_bcd_reg <= sevseg_scan_bcd;
                snap_dp_reg  <= sevseg_scan_dp_en;
            end
        end
    end

    // Registered display outputs and frame pulse; reset forces the display dark at once.
    always_ff @(posedge sevseg_scan_clk or posedge sevseg_scan_rst) begin
        if (sevseg_scan_rst) begin
            an_reg    <= 4'b1111;
            seg_reg   <= 7'b1111111;
            dp_reg    <= 1'b1;
            frame_reg <= 1'b0;
        end else begin
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            frame_reg <= frame_load;
        end
    end

    assign sevseg_scan_an    = an_reg;
    assign sevseg_scan_seg   = seg_reg;
    assign sevseg_scan_dp    = dp_reg;
    assign sevseg_scan_frame = frame_reg;

endmodule

// File: tb/tb_sevseg_scan.sv
// tb_sevseg_scan: directed bench for sevseg_scan with REFRESH_DIV=4, BLANK_CYCLES=1.
// Expectations follow SEVSEG_SCAN_LZB_EN when it is defined for the build.
module tb_sevseg_scan;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S6  = 7'b0000010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] SD  = 7'b0111111;
    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd;
    logic [3:0]  dp_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int checks = 0;
    int errors = 0;

    sevseg_scan #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .sevseg_scan_clk   (clk),
        .sevseg_scan_rst   (rst),
        .sevseg_scan_bcd   (bcd),
        .sevseg_scan_dp_en (dp_en),
        .sevseg_scan_an    (an),
        .sevseg_scan_seg   (seg),
        .sevseg_scan_dp    (dp),
        .sevseg_scan_frame (frame)
    );

    always #5 clk = ~clk;

    // Advance until a frame pulse is observed; ok=0 if none within the budget.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (frame === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // First 16 cycles after reset release: blank, digit 0 first, snapshot 0000, frame at 16.
    task automatic test_restart(input string tag);
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (frame !== (n == 16)) begin
                errors++;
                $display("FAIL %s frame n=%0d: got %b expected %b", tag, n, frame, (n == 16));
            end
            if (n == 1) begin
                checks++;
                if (an !== 4'b1111) begin
                    errors++;
                    $display("FAIL %s blank_an: got %b expected 1111", tag, an);
                end
            end
            if (n == 2) begin
                checks++;
                if (an !== 4'b1110 || seg !== S0 || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL %s first_digit: got an=%b seg=%b dp=%b expected an=1110 seg=%b dp=1",
                             tag, an, seg, dp, S0);
                end
            end
            if (n == 6) begin
                checks++;
`ifdef SEVSEG_SCAN_LZB_EN
                if (an !== 4'b1111 || seg !== OFF) begin
                    errors++;
                    $display("FAIL %s digit1_zero: got an=%b seg=%b expected an=1111 seg=%b", tag, an, seg, OFF);
                end
`else
                if (an !== 4'b1101 || seg !== S0) begin
                    errors++;
                    $display("FAIL %s digit1_zero: got an=%b seg=%b expected an=1101 seg=%b", tag, an, seg, S0);
                end
`endif
            end
        end
        $display("restart %s: checked 16 cycles after release", tag);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        bcd   = 16'h0000;
        dp_en = 4'b0000;
        #3;
        checks++;
        if (an !== 4'b1111 || seg !== OFF || dp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got an=%b seg=%b dp=%b frame=%b expected 1111 1111111 1 0",
                     an, seg, dp, frame);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1111 || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got an=%b frame=%b expected 1111 0", an, frame);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: outputs dark while held, released");
        test_restart("power_on");
    endtask

    // Hand-tabulated frames for several digit patterns, checked slot by slot.
    task automatic test_patterns();
        logic [15:0] v_bcd [5] = '{16'h1234, 16'h00AF, 16'h0070, 16'h0000, 16'h0005};
        logic [3:0]  v_dp  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        logic [6:0]  e_seg [4];
        logic [3:0]  e_an  [4];
        logic        e_dp  [4];
        logic [3:0]  x_an;
        logic [6:0]  x_seg;
        logic        x_dp;
        bit          ok;
        int          j;
        int          c;
        for (int v = 0; v < 5; v++) begin
            bcd   = v_bcd[v];
            dp_en = v_dp[v];
            e_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
            e_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
            case (v)
                0:       e_seg = '{S4, S3, S2, S1};
                1:       e_seg = '{SD, SD, S0, S0};
                2:       e_seg = '{S0, S7, S0, S0};
                3:       e_seg = '{S0, S0, S0, S0};
                default: begin
                    e_seg   = '{S5, S0, S0, S0};
                    e_dp[2] = 1'b0;
                end
            endcase
`ifdef SEVSEG_SCAN_LZB_EN
            case (v)
                1, 2: begin
                    e_an[2] = 4'b1111; e_seg[2] = OFF;
                    e_an[3] = 4'b1111; e_seg[3] = OFF;
                end
                3: begin
                    e_an[1] = 4'b1111; e_seg[1] = OFF;
                    e_an[2] = 4'b1111; e_seg[2] = OFF;
                    e_an[3] = 4'b1111; e_seg[3] = OFF;
                end
                4: begin
                    e_an[1] = 4'b1111; e_seg[1] = OFF; e_dp[1] = 1'b1;
                    e_an[3] = 4'b1111; e_seg[3] = OFF;
                end
                default: ;
            endcase
`endif
            wait_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL pattern_%h frame_timeout: got no frame expected a pulse within 40 cycles", v_bcd[v]);
            end
            for (int s = 0; s < 16; s++) begin
                @(posedge clk);
                #1;
                j     = s / 4;
                c     = s % 4;
                x_an  = (c == 0) ? 4'b1111 : e_an[j];
                x_seg = (c == 0) ? OFF : e_seg[j];
                x_dp  = (c == 0) ? 1'b1 : e_dp[j];
                checks++;
                if (an !== x_an || seg !== x_seg || dp !== x_dp || frame !== (s == 15)) begin
                    errors++;
                    $display("FAIL pattern_%h slot%0d cyc%0d: got an=%b seg=%b dp=%b frame=%b expected an=%b seg=%b dp=%b frame=%b",
                             v_bcd[v], j, c, an, seg, dp, frame, x_an, x_seg, x_dp, (s == 15));
                end
            end
            $display("pattern bcd=%h dp_en=%b: frame checked", v_bcd[v], v_dp[v]);
        end
    endtask

    // Input changes mid-frame must not reach the display until the next frame.
    task automatic test_no_tear();
        logic [6:0] e_seg [4];
        logic [3:0] e_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] x_an;
        logic [6:0] x_seg;
        bit         ok;
        int         j;
        int         c;
        bcd   = 16'h1234;
        dp_en = 4'b0000;
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL no_tear frame_timeout: got no frame expected a pulse within 40 cycles");
        end
        for (int f = 0; f < 2; f++) begin
            if (f == 0) e_seg = '{S4, S3, S2, S1};
            else        e_seg = '{S8, S7, S6, S5};
            for (int s = 0; s < 16; s++) begin
                @(posedge clk);
                #1;
                j     = s / 4;
                c     = s % 4;
                x_an  = (c == 0) ? 4'b1111 : e_an[j];
                x_seg = (c == 0) ? OFF : e_seg[j];
                checks++;
                if (an !== x_an || seg !== x_seg || frame !== (s == 15)) begin
                    errors++;
                    $display("FAIL no_tear f%0d slot%0d cyc%0d: got an=%b seg=%b frame=%b expected an=%b seg=%b frame=%b",
                             f, j, c, an, seg, frame, x_an, x_seg, (s == 15));
                end
                if (f == 0 && s == 5) bcd = 16'h5678;
            end
            $display("no_tear frame %0d checked", f);
        end
    endtask

    // Asynchronous reset while digit 2 is lit: dark before any edge, then restart at digit 0.
    task automatic test_reset_mid_slot();
        bit found = 1'b0;
        bcd   = 16'h5678;
        dp_en = 4'b1111;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (an === 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_slot find_digit2: got no an=1011 expected it within 40 cycles");
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== OFF || dp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL mid_slot_async: got an=%b seg=%b dp=%b frame=%b expected 1111 1111111 1 0",
                     an, seg, dp, frame);
        end
        #2;
        rst = 1'b0;
        $display("reset_mid_slot: asserted during digit 2, released");
        test_restart("mid_slot");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_no_tear();
        test_reset_mid_slot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevseg_scan.md
SEVSEG_SCAN -- requirements
Module: sevseg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLANK_CYCLES, default 1000, inter-digit blanking cycles at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-003 Port sevseg_scan_clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 Port sevseg_scan_rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port sevseg_scan_bcd, input, 16, four BCD digits; digit k is bits [4k+3:4k], digit 0 is rightmost; driven directly by the 4-digit up/down counter output.
REQ-006 Port sevseg_scan_dp_en, input, 4, per-digit decimal point request; bit k is digit k.
REQ-007 Port sevseg_scan_an, output, 4, active-low anode enables; bit k drives digit k.
REQ-008 Port sevseg_scan_seg, output, 7, active-low cathodes ordered {g,f,e,d,c,b,a}.
REQ-009 Port sevseg_scan_dp, output, 1, active-low decimal point cathode.
REQ-010 Port sevseg_scan_frame, output, 1, one-cycle pulse marking a snapshot load.

Function
REQ-011 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; at each wrap the digit index SHALL advance 0->1->2->3->0.
REQ-012 On the edge where prescaler = REFRESH_DIV-1 and index = 3, the snapshot register SHALL load sevseg_scan_bcd and sevseg_scan_dp_en, and sevseg_scan_frame SHALL be 1 for the following cycle only.
REQ-013 Decode and display SHALL use only snapshot values, so input changes mid-frame never tear the displayed frame.
REQ-014 All outputs SHALL be registered and SHALL reflect the prescaler, index and snapshot state of the previous cycle (one-cycle latency).
REQ-015 While prescaler < BLANK_CYCLES, an SHALL be 4'b1111, seg SHALL be 7'b1111111 and dp SHALL be 1.
REQ-016 Otherwise exactly one anode bit (the indexed digit) SHALL be 0, unless that digit is blanked per REQ-023.
REQ-017 Decode SHALL map 0..9 to standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Codes 10..15 SHALL display a dash (7'b0111111).
REQ-019 sevseg_scan_dp SHALL be 0 exactly when the indexed digit is driven and its snapshot dp_en bit is 1.

Reset
REQ-020 Asserting sevseg_scan_rst SHALL immediately force prescaler=0, index=0, snapshot bcd=0, snapshot dp_en=0, an=4'b1111, seg=7'b1111111, dp=1 and frame=0, including when asserted mid-slot.
REQ-021 After reset release, the scan SHALL restart at digit 0, prescaler 0; the display SHALL show snapshot 0000 until the first frame pulse, which occurs 4*REFRESH_DIV cycles after release.

Configuration
REQ-022 The macro SEVSEG_SCAN_LZB_EN SHALL enable leading-zero blanking.
REQ-023 With SEVSEG_SCAN_LZB_EN defined, digit k (k=3,2,1) SHALL keep its anode off for its whole slot when digits k..3 of the snapshot are all 0 and its snapshot dp_en bit is 0; codes 10..15 count as nonzero; digit 0 is never blanked.
REQ-024 Without SEVSEG_SCAN_LZB_EN, all four digits SHALL always be driven outside the blanking window.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-025 Reset mid-slot with digit 2 active -> an=1111, seg=1111111, dp=1 and frame=0 within the same cycle, before any clock edge; after release, digit 0 is scanned first.
REQ-026 bcd=16'h1234 held through one frame -> each slot is 1 cycle of an=1111 then 3 cycles of 1110/0011001, then 1101/0110000, then 1011/0100100, then 0111/1111001; frame pulses once every 16 cycles.
REQ-027 bcd changes from 16'h1234 to 16'h5678 while digit 1 is active -> digits 2 and 3 still show 2 and 1 in that frame; the next frame shows 8, 7, 6, 5.
REQ-028 bcd=16'h00AF -> digits 0 and 1 show 0111111.
REQ-029 bcd=16'h0070: with the macro, digits 3 and 2 keep an=1111 for their slots and digits 1 and 0 show 7 and 0; without the macro, digits 3 and 2 show 1000000. bcd=16'h0000 with the macro -> only digit 0 is lit.
REQ-030 dp_en=4'b0100 and bcd=16'h0005 with the macro -> digit 2 is lit as 0 with dp=0 during its active cycles, digit 3 is blanked, and dp=1 in every other slot.
